pipeline_hazard_ctrl: RTL
=========================

# pipeline_hazard_ctrl

Central stall/flush controller for the RV32I pipelined core. It replaces the ad-hoc per-stage flush wiring and the empty branch unit. It detects load-use hazards, freezes the pipeline while a multi-cycle data memory access is outstanding, and flushes the correct pipeline registers on a control-flow redirect. The stage count, branch resolution stage and load-use bubble depth are parameters, and the block keeps saturating performance counters.

## Interface
- `NUM_STAGES`, 5: number of pipeline stages. Legal range 5–8. Pipeline register k sits between stage k and stage k+1, so there are NUM_STAGES-1 registers. Stage 0 = IF, 1 = ID, 2 = EX.
- `REG_SEL`, 5: register specifier width.
- `BRANCH_STAGE`, 3: stage in which `redirect` is resolved. Legal range 2 to NUM_STAGES-2.
- `LU_BUBBLES`, 1: bubbles inserted per load-use hazard. Legal range 1–4.
- `CNT_WIDTH`, 32: width of the performance counters.

Ports (reset is synchronous and active-high, one clock):
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `id_rs1`, `id_rs2`  in  REG_SEL each  source registers of the instruction in ID.
- `id_uses_rs1`, `id_uses_rs2`  in  1 each  ID instruction actually reads rs1/rs2.
- `ex_rd`  in  REG_SEL  destination register of the instruction in EX.
- `ex_mem_read`  in  1  instruction in EX is a load.
- `redirect`  in  1  taken branch or jump resolved in BRANCH_STAGE.
- `mem_req`  in  1  data memory access active this cycle.
- `mem_ready`  in  1  data memory completes this cycle.
- `stall_pc`  out  1  hold the PC register.
- `stall`  out  NUM_STAGES-1  per-register hold; bit k is pipeline register k.
- `flush`  out  NUM_STAGES-1  per-register bubble insert; flush wins over stall in the register.
- `busy`  out  1  FSM is in MEM_WAIT.
- `perf_stall_cycles`, `perf_flushes`, `perf_load_use`  out  CNT_WIDTH each  saturating counters.

## Operation
- The FSM has two states: RUN and MEM_WAIT. Stall and flush outputs are combinational from the current state and inputs (Mealy), so they act in the same cycle.
- **Reset:** `rst`=1 forces all `flush` bits to 1 and all `stall` bits and `stall_pc` to 0. On the next edge: state RUN, counters 0, `redirect_pend` 0, bubble counter 0, `busy` 0.
- **Memory wait (highest priority):**
  - In RUN, `mem_req` && !`mem_ready` starts a wait. In the same cycle: `stall_pc`=1, `stall[NUM_STAGES-3:0]`=1, `flush[NUM_STAGES-2]`=1 (WB receives bubbles). Next state is MEM_WAIT.
  - MEM_WAIT drives the same outputs while `mem_ready`=0.
  - When `mem_ready`=1 the stalls are released in that cycle and the next state is RUN.
- **Redirect:**
  - In RUN with no memory wait, `redirect`=1 sets `flush[k]`=1 for every k < BRANCH_STAGE. No stalls are asserted.
  - A redirect suppresses any load-use detection in that cycle and clears the bubble counter.
  - `redirect`=1 while stalled (entry cycle or MEM_WAIT) sets `redirect_pend`. The flush is applied in the release cycle (`mem_ready`=1), and `redirect_pend` clears on that edge.
  - `perf_flushes` increments once per applied flush.
- **Load-use:**
  - Hit condition: `ex_mem_read` && `ex_rd`≠0 && ((`id_uses_rs1` && `id_rs1`==`ex_rd`) || (`id_uses_rs2` && `id_rs2`==`ex_rd`)).
  - In RUN with no redirect and no memory wait, a hit drives `stall_pc`=1, `stall[0]`=1 and `flush[1]`=1, loads the bubble counter with LU_BUBBLES-1, and increments `perf_load_use`.
  - While the bubble counter is nonzero the same outputs are driven and the counter decrements. These cycles are not recounted as load-use events.
- **Priority:** rst > memory wait > redirect (or pending redirect) > bubble counter > new load-use hit.
- **Counters:**
  - `perf_stall_cycles` increments on every cycle with `stall_pc`=1.
  - All counters saturate at all-ones and do not wrap.
  - All counters are held at 0 during rst.

## Timing
- Stall and flush outputs: 0-cycle latency from their inputs (combinational).
- State, `busy`, `redirect_pend`, bubble counter and counters: update on the rising `clk` edge.
- Load-use with LU_BUBBLES=N: `stall_pc` is high for exactly N consecutive cycles starting in the detection cycle.
- Memory wait of W cycles (`mem_ready` low W cycles, then high): stall is high for W cycles. `busy` is high for W cycles starting one cycle after entry. The release cycle has no stall.
- Reset asserted mid-wait or mid-bubble: takes effect on the next edge. No pending flush survives the reset.

## Test plan
- **Reset:** assert rst 2 cycles with `mem_req`=1 and `redirect`=1 -> during reset `flush`=4'b1111, `stall`=0, `stall_pc`=0. After release: all counters 0, `busy`=0.
- **Load-use:** `ex_mem_read`=1, `ex_rd`=5, `id_rs2`=5, `id_uses_rs2`=1, LU_BUBBLES=2 -> `stall_pc`/`stall[0]`/`flush[1]` high 2 cycles, `perf_load_use`=1, `perf_stall_cycles`=2.
- **x0 and unused operand:** `ex_rd`=0 with matching `id_rs1`=0 -> no stall. `ex_rd`=7, `id_rs1`=7, `id_uses_rs1`=0 -> no stall.
- **Redirect vs load-use:** `redirect`=1 at the same time as a load-use hit, BRANCH_STAGE=3 -> `flush`=4'b0111, `stall_pc`=0, `perf_flushes`=1, `perf_load_use`=0.
- **Memory wait with pending redirect:** `mem_req`=1, `mem_ready`=0 for 3 cycles, `redirect` pulsed in wait cycle 2 -> stall 3 cycles, `flush[3]`=1 during the wait, `busy` 2→3 cycles as per Timing. Release cycle shows `flush`=4'b0111 and stall 0.
- **Counter saturation:** CNT_WIDTH=4 with 20 consecutive stall cycles -> `perf_stall_cycles` holds at 4'hF.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//
// Central stall/flush controller for the pipelined RV32I core. It detects
// load-use hazards, freezes the front of the pipeline while a multi-cycle
// data memory access is outstanding, and flushes the pipeline registers
// younger than the branch resolution stage on a control-flow redirect.
// Stall/flush are Mealy outputs so they act in the cycle they are decided.
//
// Handshake note: mem_req marks a data access active this cycle; mem_ready
// marks the cycle it completes. An access with mem_req && !mem_ready holds
// the pipeline until the first cycle that mem_ready is high (release cycle),
// which itself carries no stall.
//
// Parameters:
//   NUM_STAGES   pipeline stages (5..8); NUM_STAGES-1 pipeline registers
//   REG_SEL      register specifier width
//   BRANCH_STAGE stage that resolves redirect (2..NUM_STAGES-2)
//   LU_BUBBLES   bubbles per load-use hazard (1..4)
//   CNT_WIDTH    performance counter width
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   id_rs1/id_rs2            source registers of the ID instruction
//   id_uses_rs1/id_uses_rs2  ID instruction really reads rs1/rs2
//   ex_rd, ex_mem_read       destination / is-load of the EX instruction
//   redirect                 taken branch/jump resolved in BRANCH_STAGE
//   mem_req, mem_ready       data memory access active / completing
//   stall_pc                 hold the PC
//   stall[k], flush[k]       hold / bubble pipeline register k
//   busy                     FSM is in MEM_WAIT (exposes the FSM state)
//   perf_*                   saturating performance counters

module pipeline_hazard_ctrl #(
    parameter int NUM_STAGES   = 5,
    parameter int REG_SEL      = 5,
    parameter int BRANCH_STAGE = 3,
    parameter int LU_BUBBLES   = 1,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_SEL-1:0]    id_rs1,
    input  logic [REG_SEL-1:0]    id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_SEL-1:0]    ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  redirect,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  stall_pc,
    output logic [NUM_STAGES-2:0] stall,
    output logic [NUM_STAGES-2:0] flush,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  perf_stall_cycles,
    output logic [CNT_WIDTH-1:0]  perf_flushes,
    output logic [CNT_WIDTH-1:0]  perf_load_use
);

    localparam int NR = NUM_STAGES - 1;

    // Memory wait holds everything up to the register feeding WB and
    // bubbles that last register so WB does not retire a stale instruction.
    localparam logic [NR-1:0] WAIT_STALL  = NR'((1 << (NR - 1)) - 1);
    localparam logic [NR-1:0] WAIT_FLUSH  = NR'(1) << (NR - 1);
    // Redirect kills every register younger than the resolving stage.
    localparam logic [NR-1:0] REDIR_FLUSH = NR'((1 << BRANCH_STAGE) - 1);
    localparam logic [NR-1:0] LU_STALL    = NR'(1);
    localparam logic [NR-1:0] LU_FLUSH    = NR'(2);

    typedef enum logic {
        S_RUN      = 1'b0,
        S_MEM_WAIT = 1'b1
    } state_t;

    state_t     state;
    logic       redirect_pend;
    logic [1:0] bub_cnt;

    logic lu_hit;
    logic mem_stall;
    logic redir_now;
    logic bubble_now;
    logic lu_new;

    always_comb begin
        lu_hit = ex_mem_read && (ex_rd != '0) &&
                 ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                  (id_uses_rs2 && (id_rs2 == ex_rd)));

        mem_stall  = !rst && !mem_ready &&
                     ((state == S_MEM_WAIT) || mem_req);
        // A redirect that arrived during a stall is applied in the release
        // cycle, which is the first cycle mem_stall drops.
        redir_now  = !rst && !mem_stall && (redirect || redirect_pend);
        bubble_now = !rst && !mem_stall && !redir_now && (bub_cnt != 2'd0);
        lu_new     = !rst && !mem_stall && !redir_now && (bub_cnt == 2'd0) && lu_hit;

        stall_pc = 1'b0;
        stall    = '0;
        flush    = '0;
        if (rst) begin
            flush = '1;
        end else if (mem_stall) begin
            stall_pc = 1'b1;
            stall    = WAIT_STALL;
            flush    = WAIT_FLUSH;
        end else if (redir_now) begin
            flush = REDIR_FLUSH;
        end else if (bubble_now || lu_new) begin
            stall_pc = 1'b1;
            stall    = LU_STALL;
            flush    = LU_FLUSH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= S_RUN;
            busy              <= 1'b0;
            redirect_pend     <= 1'b0;
            bub_cnt           <= 2'd0;
            perf_stall_cycles <= '0;
            perf_flushes      <= '0;
            perf_load_use     <= '0;
        end else begin
            if (state == S_RUN) begin
                if (mem_req && !mem_ready) begin
                    state <= S_MEM_WAIT;
                    busy  <= 1'b1;
                end
            end else begin
                if (mem_ready) begin
                    state <= S_RUN;
                    busy  <= 1'b0;
                end
            end

            if (mem_stall) begin
                if (redirect) begin
                    redirect_pend <= 1'b1;
                end
            end else begin
                redirect_pend <= 1'b0;
            end

            // The bubble count freezes while memory holds the pipeline.
            if (!mem_stall) begin
                if (redir_now) begin
                    bub_cnt <= 2'd0;
                end else if (bubble_now) begin
                    bub_cnt <= bub_cnt - 2'd1;
                end else if (lu_new) begin
                    bub_cnt <= 2'(LU_BUBBLES - 1);
                end
            end

            if (stall_pc && (perf_stall_cycles != '1)) begin
                perf_stall_cycles <= perf_stall_cycles + CNT_WIDTH'(1);
            end
            if (redir_now && (perf_flushes != '1)) begin
                perf_flushes <= perf_flushes + CNT_WIDTH'(1);
            end
            if (lu_new && (perf_load_use != '1)) begin
                perf_load_use <= perf_load_use + CNT_WIDTH'(1);
            end
        end
    end

endmodule
